// File: rtl/pointwise_conv_stream.sv
// pointwise_conv_stream
// ---------------------
// Streaming 1x1 (pointwise) convolution. One pixel of IN_CHANNELS signed
// fixed-point values is buffered, then OUT_CHANNELS dot products against a
// weight matrix W[oc][ic] are computed PARALLELISM output channels at a
// time. Results are rounded (half up), saturated to N bits and streamed out
// one channel per handshake.
//
// Optional feature: define PW_RELU6_EN to clamp every output to [0, 6.0]
// (ReLU6) after rounding and saturation.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   w_we/w_addr/w_data  weight write port, address = oc*IN_CHANNELS+ic,
//                       only honoured while idle
//   in_valid/in_ready/  input stream, channels 0..IN_CHANNELS-1 per pixel
//   in_data
//   out_valid/out_ready output stream, one beat per output channel;
//   out_data/           out_last marks channel OUT_CHANNELS-1
//   out_channel/out_last
//   busy                high whenever the engine is not idle
module pointwise_conv_stream #(
   parameter int N            = 16,
   parameter int Q            = 8,
   parameter int IN_CHANNELS  = 40,
   parameter int OUT_CHANNELS = 48,
   parameter int PARALLELISM  = 4
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             w_we,
   input  logic [$clog2(IN_CHANNELS*OUT_CHANNELS)-1:0]      w_addr,
   input  logic [N-1:0]                                     w_data,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [N-1:0]                                     in_data,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [N-1:0]                                     out_data,
   output logic [((OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1)-1:0] out_channel,
   output logic                                             out_last,
   output logic                                             busy
);
   localparam int CW    = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
   localparam int NG    = (OUT_CHANNELS + PARALLELISM - 1) / PARALLELISM;
   localparam int GW    = (NG > 1) ? $clog2(NG) : 1;
   localparam int PW    = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
   localparam int IW    = $clog2(IN_CHANNELS);
   localparam int KW    = $clog2(IN_CHANNELS + 1);
   localparam int DEPTH = NG * IN_CHANNELS;
   localparam int BW    = $clog2(DEPTH);
   localparam int ACC_W = 2 * N + $clog2(IN_CHANNELS);
   localparam int SW    = ACC_W + 1;

   localparam logic signed [SW-1:0] ROUND = SW'(1) <<< (Q - 1);
   localparam logic signed [SW-1:0] MAX_S = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_S = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef PW_RELU6_EN
   localparam logic signed [SW-1:0] RELU_HI = SW'(6) <<< Q;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

   state_t          state_reg, state_next;
   logic [GW-1:0]   g_reg, g_next;
   logic [KW-1:0]   k_reg, k_next;
   logic [PW-1:0]   p_reg, p_next;
   logic [IW-1:0]   ld_idx_reg, ld_idx_next;

   logic            in_fire, out_fire, last_oc;
   logic [31:0]     cur_oc;
   logic [N-1:0]    act_data;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign cur_oc   = 32'(g_reg) * PARALLELISM + 32'(p_reg);
   assign last_oc  = (cur_oc == 32'(OUT_CHANNELS - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         g_reg      <= '0;
         k_reg      <= '0;
         p_reg      <= '0;
         ld_idx_reg <= '0;
      end else begin
         state_reg  <= state_next;
         g_reg      <= g_next;
         k_reg      <= k_next;
         p_reg      <= p_next;
         ld_idx_reg <= ld_idx_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next  = state_reg;
      g_next      = g_reg;
      k_next      = k_reg;
      p_next      = p_reg;
      ld_idx_next = ld_idx_reg;
      case (state_reg)
         IDLE: if (in_fire) begin
            state_next  = LOAD;
            ld_idx_next = IW'(1);
         end
         LOAD: if (in_fire) begin
            if (ld_idx_reg == IW'(IN_CHANNELS - 1)) begin
               state_next = MAC;
               g_next     = '0;
               k_next     = '0;
            end else begin
               ld_idx_next = ld_idx_reg + 1'b1;
            end
         end
         // k counts 0..IN_CHANNELS: one extra cycle drains the product register
         MAC: if (k_reg == KW'(IN_CHANNELS)) begin
            state_next = EMIT;
            p_next     = '0;
         end else begin
            k_next = k_reg + 1'b1;
         end
         EMIT: if (out_fire) begin
            if (last_oc) begin
               state_next = IDLE;
            end else if (p_reg == PW'(PARALLELISM - 1)) begin
               state_next = MAC;
               g_next     = g_reg + 1'b1;
               k_next     = '0;
            end else begin
               p_next = p_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      out_channel = '0;
      out_last    = 1'b0;
      out_data    = '0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         LOAD: in_ready = 1'b1;
         EMIT: begin
            out_valid   = 1'b1;
            out_channel = CW'(cur_oc);
            out_last    = last_oc;
            out_data    = act_data;
         end
         default: ;
      endcase
   end

   // ---------------- input pixel buffer ----------------
   logic signed [N-1:0] in_buf_reg [IN_CHANNELS];
   logic signed [N-1:0] mac_in;

   always_ff @(posedge clk) begin
      if (in_fire)
         in_buf_reg[(state_reg == IDLE) ? IW'(0) : ld_idx_reg] <= in_data;
   end

   assign mac_in = in_buf_reg[(k_reg < KW'(IN_CHANNELS)) ? IW'(k_reg) : IW'(0)];

   // ---------------- weight addressing ----------------
   // Weights are banked by lane: bank p holds output channels oc with
   // oc % PARALLELISM == p, at bank address (oc / PARALLELISM)*IN_CHANNELS+ic.
   // The read address is taken from the next-state counters so the
   // registered read lines up with buffer[k] in the same MAC cycle.
   logic [31:0]   wa, w_oc, w_ic, w_lane, rd_k;
   logic [BW-1:0] w_baddr, rd_addr;
   logic          w_ok;

   always_comb begin
      wa      = 32'(w_addr);
      w_oc    = wa / IN_CHANNELS;
      w_ic    = wa % IN_CHANNELS;
      w_lane  = w_oc % PARALLELISM;
      w_baddr = BW'((w_oc / PARALLELISM) * IN_CHANNELS + w_ic);
      w_ok    = w_we && (state_reg == IDLE) && (wa < 32'(IN_CHANNELS * OUT_CHANNELS));
      rd_k    = (k_next < KW'(IN_CHANNELS)) ? 32'(k_next) : 32'(IN_CHANNELS - 1);
      rd_addr = BW'(32'(g_next) * IN_CHANNELS + rd_k);
   end

   // ---------------- MAC lanes ----------------
   logic signed [ACC_W-1:0] acc_lane [PARALLELISM];

   for (genvar gi = 0; gi < PARALLELISM; gi++) begin : g_lane
      logic signed [N-1:0]     mem [DEPTH];
      logic signed [N-1:0]     rd_data_reg;
      logic signed [2*N-1:0]   product_reg;
      logic signed [ACC_W-1:0] acc_reg;

      always_ff @(posedge clk) begin
         if (w_ok && (w_lane == 32'(gi)))
            mem[w_baddr] <= w_data;
         rd_data_reg <= mem[rd_addr];
      end

      // product for channel k is registered at cycle k and added at k+1;
      // cycle 0 clears the accumulator instead of adding a stale product
      always_ff @(posedge clk) begin
         if (rst) begin
            product_reg <= '0;
            acc_reg     <= '0;
         end else begin
            product_reg <= (2*N)'(mac_in) * (2*N)'(rd_data_reg);
            if (state_reg == MAC) begin
               if (k_reg == '0)
                  acc_reg <= '0;
               else
                  acc_reg <= acc_reg + ACC_W'(product_reg);
            end
         end
      end

      assign acc_lane[gi] = acc_reg;
   end

   // ---------------- round / saturate / activation ----------------
   logic signed [SW-1:0] sum, shifted, sat;

   always_comb begin
      sum     = SW'(acc_lane[p_reg]) + ROUND;
      shifted = sum >>> Q;
      if (shifted > MAX_S)
         sat = MAX_S;
      else if (shifted < MIN_S)
         sat = MIN_S;
      else
         sat = shifted;
`ifdef PW_RELU6_EN
      if (sat[SW-1])
         sat = '0;
      else if (sat > RELU_HI)
         sat = RELU_HI;
`else
      // no activation: the saturated signed value is emitted as-is
`endif
      act_data = sat[N-1:0];
   end

endmodule

// File: doc/pointwise_conv_stream.md
POINTWISE_CONV_STREAM -- requirements
Module: pointwise_conv_stream

Interface
- REQ-001: Parameter N, default 16, signed fixed-point data and weight width.
- REQ-002: Parameter Q, default 8, fractional bits (Q < N).
- REQ-003: Parameter IN_CHANNELS, default 40, input channels per pixel (>= 2).
- REQ-004: Parameter OUT_CHANNELS, default 48, output channels per pixel (>= 1).
- REQ-005: Parameter PARALLELISM, default 4, concurrent MAC lanes (1..OUT_CHANNELS; need not divide OUT_CHANNELS).
- REQ-006: clk  in  1  clock; all logic on its rising edge.
- REQ-007: rst  in  1  reset, synchronous, active-high.
- REQ-008: w_we  in  1; w_addr  in  clog2(IN_CHANNELS*OUT_CHANNELS); w_data  in  N. Weight write port, address = oc*IN_CHANNELS+ic.
- REQ-009: in_valid  in  1; in_ready  out  1; in_data  in  N. Input stream, channel order 0..IN_CHANNELS-1 per pixel.
- REQ-010: out_valid  out  1; out_ready  in  1; out_data  out  N; out_channel  out  clog2(OUT_CHANNELS); out_last  out  1 (final channel of pixel).
- REQ-011: busy  out  1  high in any state other than IDLE.

Function
- REQ-012: FSM states IDLE, LOAD, MAC, EMIT.
- REQ-013: IDLE: in_ready=1; first accepted beat (in_valid&&in_ready) stores to input buffer[0] and moves to LOAD.
- REQ-014: LOAD: in_ready=1; beats fill buffer[1..IN_CHANNELS-1]; the beat filling IN_CHANNELS-1 moves to MAC with group g=0.
- REQ-015: MAC: in_ready=0; for group g, lane p computes oc=g*PARALLELISM+p; each cycle ic=0..IN_CHANNELS-1 adds buffer[ic]*W[oc][ic] to acc[p]; acc cleared on entering MAC.
- REQ-016: MAC occupies exactly IN_CHANNELS+1 cycles per group (one multiply register stage), then EMIT.
- REQ-017: Accumulator width 2N+clog2(IN_CHANNELS); full-precision products, no intermediate truncation or saturation.
- REQ-018: Output = (acc + 2^(Q-1)) >>> Q (round half up, arithmetic shift), then saturate to [-2^(N-1), 2^(N-1)-1].
- REQ-019: EMIT: lanes presented in order p=0..; out_valid held with data stable until out_ready; lane advances only on out_valid&&out_ready.
- REQ-020: Lanes with oc >= OUT_CHANNELS in the last group are skipped, never emitted.
- REQ-021: After last valid lane of group g: if more groups, g+1 and MAC; else IDLE.
- REQ-022: out_last=1 only on the beat with out_channel=OUT_CHANNELS-1.
- REQ-023: Weight writes accepted only in IDLE; w_we in other states ignored with no effect.
- REQ-024: Out-of-range w_addr (>= IN_CHANNELS*OUT_CHANNELS) ignored.
- REQ-025: Back-to-back pixels: next pixel's first beat accepted in IDLE the cycle after the final handshake.
- REQ-026: Weight memory inferable as block RAM (one read per lane per cycle, no reset).

Reset
- REQ-027: rst returns FSM to IDLE from any state, discarding partial pixel and accumulators.
- REQ-028: Reset values: out_valid=0, out_data=0, out_channel=0, out_last=0, busy=0, in_ready=1 after reset deassertion.
- REQ-029: Weight memory contents are not altered by rst.

Configuration
- REQ-030: Macro PW_RELU6_EN defined: after REQ-018, output clamped to [0, 6*2^Q] (ReLU6).
- REQ-031: PW_RELU6_EN undefined: output is the saturated signed value of REQ-018, no activation.

Verification (N=16, Q=8, IN_CHANNELS=4, OUT_CHANNELS=6, PARALLELISM=4)
- REQ-032: All weights 0x0100, inputs 0x0100,0x0200,0x0300,0x0400, out_ready=1 -> 6 beats, channels 0..5, each 0x0A00, out_last only on channel 5, only 2 lanes emitted in group 1.
- REQ-033: Weights 0x7FFF, inputs 0x7FFF x4 -> every output 0x7FFF (saturation); with PW_RELU6_EN -> 0x0600.
- REQ-034: Weights 0x0100, inputs 0xFF00 x4 -> outputs 0xFC00 without macro, 0x0000 with PW_RELU6_EN.
- REQ-035: out_ready low 5 cycles on channel 2 -> out_valid, out_data, out_channel stable for those cycles; no beat lost or duplicated.
- REQ-036: rst asserted mid-MAC, then full new pixel -> outputs depend only on new pixel; w_we during MAC does not change results.
